// File: rtl/queue_dequeue_client.sv
// Dequeue requester for queue_manager: scheduler commands in, descriptors out, commits back.
// Optional statistics counters are enabled by defining DEQ_CLIENT_STATS_EN.
module queue_dequeue_client #(
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int REQ_TAG_WIDTH     = 3,
  parameter int OP_TAG_WIDTH      = 8,
  parameter int QUEUE_PTR_WIDTH   = 16,
  parameter int ADDR_WIDTH        = 64,
  parameter int COMMIT_FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic [QUEUE_INDEX_WIDTH-1:0] cmd_queue,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,

  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_dequeue_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]     m_axis_dequeue_req_tag,
  output logic                         m_axis_dequeue_req_valid,
  input  logic                         m_axis_dequeue_req_ready,

  input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_dequeue_resp_queue,
  input  logic [QUEUE_PTR_WIDTH-1:0]   s_axis_dequeue_resp_ptr,
  input  logic [ADDR_WIDTH-1:0]        s_axis_dequeue_resp_addr,
  input  logic [REQ_TAG_WIDTH-1:0]     s_axis_dequeue_resp_tag,
  input  logic [OP_TAG_WIDTH-1:0]      s_axis_dequeue_resp_op_tag,
  input  logic                         s_axis_dequeue_resp_empty,
  input  logic                         s_axis_dequeue_resp_error,
  input  logic                         s_axis_dequeue_resp_valid,
  output logic                         s_axis_dequeue_resp_ready,

  output logic [OP_TAG_WIDTH-1:0]      m_axis_dequeue_commit_op_tag,
  output logic                         m_axis_dequeue_commit_valid,
  input  logic                         m_axis_dequeue_commit_ready,

  output logic [QUEUE_INDEX_WIDTH-1:0] desc_queue,
  output logic [QUEUE_PTR_WIDTH-1:0]   desc_ptr,
  output logic [ADDR_WIDTH-1:0]        desc_addr,
  output logic [OP_TAG_WIDTH-1:0]      desc_op_tag,
  output logic                         desc_valid,
  input  logic                         desc_ready,

`ifdef DEQ_CLIENT_STATS_EN
  output logic [31:0]                  stat_req_cnt,
  output logic [31:0]                  stat_empty_cnt,
  output logic [31:0]                  stat_err_cnt,
`endif
  output logic [REQ_TAG_WIDTH:0]       outstanding,
  output logic                         tag_err
);

  localparam int MAX_OUT = 1 << REQ_TAG_WIDTH;
  localparam int FIFO_AW = $clog2(COMMIT_FIFO_DEPTH);
  localparam logic [REQ_TAG_WIDTH:0] OUT_ONE   = {{REQ_TAG_WIDTH{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]       CNT_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW+1:0]     RSV_LIMIT = (FIFO_AW+2)'(COMMIT_FIFO_DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                     state, state_next;
  logic                       active;
  logic [MAX_OUT-1:0]         tag_busy;
  logic [MAX_OUT-1:0]         alloc_mask, free_mask;
  logic [REQ_TAG_WIDTH-1:0]   alloc_tag;
  logic                       tag_avail;

  logic                       cmd_hs, req_hs, resp_hs, resp_hit, resp_normal, tag_free;
  logic                       desc_hs, commit_hs;

  logic [OP_TAG_WIDTH-1:0]    fifo_mem [COMMIT_FIFO_DEPTH];
  logic [FIFO_AW-1:0]         fifo_wr_ptr, fifo_rd_ptr;
  logic [FIFO_AW:0]           fifo_count;
  logic [FIFO_AW+1:0]         fifo_reserved;

  // Lowest free tag wins: scanning downward leaves the smallest index last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    alloc_tag = '0;
    tag_avail = 1'b0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (!tag_busy[i]) begin
        alloc_tag = REQ_TAG_WIDTH'(i);
        tag_avail = 1'b1;
      end
    end
  end

  always_comb begin
    state_next               = state;
    cmd_ready                = 1'b0;
    m_axis_dequeue_req_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = active && tag_avail;
        if (cmd_valid && cmd_ready) state_next = REQ;
      end
      REQ: begin
        m_axis_dequeue_req_valid = 1'b1;
        if (m_axis_dequeue_req_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_hs      = cmd_valid && cmd_ready;
  assign req_hs      = m_axis_dequeue_req_valid && m_axis_dequeue_req_ready;
  assign resp_hs     = s_axis_dequeue_resp_valid && s_axis_dequeue_resp_ready;
  assign resp_hit    = tag_busy[s_axis_dequeue_resp_tag];
  assign tag_free    = resp_hs && resp_hit;
  assign resp_normal = tag_free && !s_axis_dequeue_resp_empty && !s_axis_dequeue_resp_error;
  assign desc_hs     = desc_valid && desc_ready;
  assign commit_hs   = m_axis_dequeue_commit_valid && m_axis_dequeue_commit_ready;

  always_comb begin
    alloc_mask = '0;
    free_mask  = '0;
    if (cmd_hs)   alloc_mask[alloc_tag]               = 1'b1;
    if (tag_free) free_mask[s_axis_dequeue_resp_tag]  = 1'b1;
  end

  // The desc slot holds a claim on one FIFO entry so its eventual commit push always fits.
  assign fifo_reserved = {1'b0, fifo_count} + {{(FIFO_AW+1){1'b0}}, desc_valid};
  assign s_axis_dequeue_resp_ready = active && (!desc_valid || desc_ready) &&
                                     (fifo_reserved < RSV_LIMIT);

  assign m_axis_dequeue_commit_valid  = (fifo_count != '0);
  assign m_axis_dequeue_commit_op_tag = fifo_mem[fifo_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!rst_n) begin
      state                    <= IDLE;
      active                   <= 1'b0;
      tag_busy                 <= '0;
      outstanding              <= '0;
      tag_err                  <= 1'b0;
      m_axis_dequeue_req_queue <= '0;
      m_axis_dequeue_req_tag   <= '0;
    end else begin
      state    <= state_next;
      active   <= 1'b1;
      tag_busy <= (tag_busy | alloc_mask) & ~free_mask;
      tag_err  <= resp_hs && !resp_hit;
      case ({cmd_hs, tag_free})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase
      if (cmd_hs) begin
        m_axis_dequeue_req_queue <= cmd_queue;
        m_axis_dequeue_req_tag   <= alloc_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_valid  <= 1'b0;
      desc_queue  <= '0;
      desc_ptr    <= '0;
      desc_addr   <= '0;
      desc_op_tag <= '0;
    end else begin
      if (resp_normal) begin
        desc_valid  <= 1'b1;
        desc_queue  <= s_axis_dequeue_resp_queue;
        desc_ptr    <= s_axis_dequeue_resp_ptr;
        desc_addr   <= s_axis_dequeue_resp_addr;
        desc_op_tag <= s_axis_dequeue_resp_op_tag;
      end else if (desc_hs) begin
        desc_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_count  <= '0;
    end else begin
      if (desc_hs)   fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
      if (commit_hs) fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
      case ({desc_hs, commit_hs})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage array is left unreset; fifo_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (desc_hs) fifo_mem[fifo_wr_ptr] <= desc_op_tag;
  end

`ifdef DEQ_CLIENT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_req_cnt   <= '0;
      stat_empty_cnt <= '0;
      stat_err_cnt   <= '0;
    end else begin
      if (req_hs && stat_req_cnt != '1)
        stat_req_cnt <= stat_req_cnt + 32'd1;
      if (tag_free && s_axis_dequeue_resp_empty && stat_empty_cnt != '1)
        stat_empty_cnt <= stat_empty_cnt + 32'd1;
      if (tag_free && s_axis_dequeue_resp_error && stat_err_cnt != '1)
        stat_err_cnt <= stat_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_queue_dequeue_client.sv
// Scoreboard bench for queue_dequeue_client: stimulus pushes expectations, monitors pop on handshakes.
// Covers allocation, tag exhaustion, empty/error/stray responses, commit backpressure and reset.
module tb_queue_dequeue_client;

  typedef struct packed {
    logic [7:0]  queue;
    logic [15:0] ptr;
    logic [63:0] addr;
    logic [7:0]  op_tag;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd_queue;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  req_queue;
  logic [2:0]  req_tag;
  logic        req_valid, req_ready;
  logic [7:0]  resp_queue;
  logic [15:0] resp_ptr;
  logic [63:0] resp_addr;
  logic [2:0]  resp_tag;
  logic [7:0]  resp_op_tag;
  logic        resp_empty, resp_error, resp_valid, resp_ready;
  logic [7:0]  commit_op_tag;
  logic        commit_valid, commit_ready;
  logic [7:0]  desc_queue;
  logic [15:0] desc_ptr;
  logic [63:0] desc_addr;
  logic [7:0]  desc_op_tag;
  logic        desc_valid, desc_ready;
  logic [3:0]  outstanding;
  logic        tag_err;
`ifdef DEQ_CLIENT_STATS_EN
  logic [31:0] stat_req_cnt, stat_empty_cnt, stat_err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int desc_cnt = 0;
  int tag_err_pulses = 0;

  logic [10:0] exp_req_q[$];
  desc_t       exp_desc_q[$];
  logic [7:0]  exp_commit_q[$];

  always #5 clk = ~clk;

  queue_dequeue_client dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .cmd_queue                    (cmd_queue),
    .cmd_valid                    (cmd_valid),
    .cmd_ready                    (cmd_ready),
    .m_axis_dequeue_req_queue     (req_queue),
    .m_axis_dequeue_req_tag       (req_tag),
    .m_axis_dequeue_req_valid     (req_valid),
    .m_axis_dequeue_req_ready     (req_ready),
    .s_axis_dequeue_resp_queue    (resp_queue),
    .s_axis_dequeue_resp_ptr      (resp_ptr),
    .s_axis_dequeue_resp_addr     (resp_addr),
    .s_axis_dequeue_resp_tag      (resp_tag),
    .s_axis_dequeue_resp_op_tag   (resp_op_tag),
    .s_axis_dequeue_resp_empty    (resp_empty),
    .s_axis_dequeue_resp_error    (resp_error),
    .s_axis_dequeue_resp_valid    (resp_valid),
    .s_axis_dequeue_resp_ready    (resp_ready),
    .m_axis_dequeue_commit_op_tag (commit_op_tag),
    .m_axis_dequeue_commit_valid  (commit_valid),
    .m_axis_dequeue_commit_ready  (commit_ready),
    .desc_queue                   (desc_queue),
    .desc_ptr                     (desc_ptr),
    .desc_addr                    (desc_addr),
    .desc_op_tag                  (desc_op_tag),
    .desc_valid                   (desc_valid),
    .desc_ready                   (desc_ready),
`ifdef DEQ_CLIENT_STATS_EN
    .stat_req_cnt                 (stat_req_cnt),
    .stat_empty_cnt               (stat_empty_cnt),
    .stat_err_cnt                 (stat_err_cnt),
`endif
    .outstanding                  (outstanding),
    .tag_err                      (tag_err)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitors sample on the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) begin
        check("req_expected", exp_req_q.size() != 0, 1'b1);
        if (exp_req_q.size() != 0) begin
          logic [10:0] e;
          e = exp_req_q.pop_front();
          check("req_queue", req_queue, e[10:3]);
          check("req_tag", req_tag, e[2:0]);
        end
      end
      if (desc_valid && desc_ready) begin
        desc_cnt++;
        check("desc_expected", exp_desc_q.size() != 0, 1'b1);
        if (exp_desc_q.size() != 0) begin
          desc_t d;
          d = exp_desc_q.pop_front();
          check("desc_queue", desc_queue, d.queue);
          check("desc_ptr", desc_ptr, d.ptr);
          check("desc_addr", desc_addr, d.addr);
          check("desc_op_tag", desc_op_tag, d.op_tag);
        end
      end
      if (commit_valid && commit_ready) begin
        check("commit_expected", exp_commit_q.size() != 0, 1'b1);
        if (exp_commit_q.size() != 0) check("commit_op_tag", commit_op_tag, exp_commit_q.pop_front());
      end
      if (tag_err) tag_err_pulses++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] q, input logic [2:0] exp_tag);
    int n = 0;
    exp_req_q.push_back({q, exp_tag});
    cmd_queue = q;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("cmd_accept_in_time", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_resp(input logic [2:0] tag, input logic [7:0] op, input logic empty,
                           input logic error, input logic exp_desc);
    int n = 0;
    desc_t d;
    d.queue  = {5'b10000, tag};
    d.ptr    = {8'h01, op};
    d.addr   = {56'hA5A5_0000_0000_00, op};
    d.op_tag = op;
    if (exp_desc) begin
      exp_desc_q.push_back(d);
      exp_commit_q.push_back(op);
    end
    resp_queue  = d.queue;
    resp_ptr    = d.ptr;
    resp_addr   = d.addr;
    resp_tag    = tag;
    resp_op_tag = op;
    resp_empty  = empty;
    resp_error  = error;
    resp_valid  = 1'b1;
    @(negedge clk);
    while (!resp_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("resp_accept_in_time", resp_ready, 1'b1);
    @(posedge clk);
    #1 resp_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    cmd_queue = '0; cmd_valid = 1'b0;
    req_ready = 1'b1;
    resp_queue = '0; resp_ptr = '0; resp_addr = '0; resp_tag = '0; resp_op_tag = '0;
    resp_empty = 1'b0; resp_error = 1'b0; resp_valid = 1'b0;
    commit_ready = 1'b1;
    desc_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_desc_valid", desc_valid, 1'b0);
    check("rst_commit_valid", commit_valid, 1'b0);
    check("rst_outstanding", outstanding, 4'd0);
    check("rst_tag_err", tag_err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(2);

    // Single transaction: queue 5, tag 0, op_tag 0x21
    send_cmd(8'd5, 3'd0);
    @(negedge clk);
    check("req_valid_latency", req_valid, 1'b1);
    @(posedge clk); #1;
    check("outstanding_one", outstanding, 4'd1);
    send_resp(3'd0, 8'h21, 1'b0, 1'b0, 1'b1);
    cycles(4);
    check("outstanding_after_single", outstanding, 4'd0);

    // Eight commands with responses withheld: tags 0..7, then exhaustion
    for (int i = 0; i < 8; i++) send_cmd(8'h30 + 8'(i), 3'(i));
    cycles(2);
    @(negedge clk);
    check("full_outstanding", outstanding, 4'd8);
    check("full_cmd_ready", cmd_ready, 1'b0);
    @(posedge clk); #1;
    send_resp(3'd3, 8'h33, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("cmd_ready_after_free", cmd_ready, 1'b1);
    check("outstanding_after_free", outstanding, 4'd7);
    @(posedge clk); #1;

    // Empty response: tag freed, no descriptor
    send_resp(3'd2, 8'h32, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("empty_outstanding", outstanding, 4'd6);
    check("empty_no_desc", desc_valid, 1'b0);
    @(posedge clk); #1;

    // Tag 6 answered, then answered again while free -> tag_err pulse
    send_resp(3'd6, 8'h36, 1'b0, 1'b0, 1'b1);
    send_resp(3'd6, 8'h66, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("tag_err_pulse", tag_err, 1'b1);
    check("tag_err_outstanding", outstanding, 4'd5);
    check("tag_err_no_desc", desc_valid, 1'b0);
    @(negedge clk);
    check("tag_err_single", tag_err, 1'b0);
    @(posedge clk); #1;

    // Error response: tag freed, no descriptor
    send_resp(3'd7, 8'h37, 1'b0, 1'b1, 1'b0);
    cycles(2);
    check("error_outstanding", outstanding, 4'd4);

    // Commit backpressure: tags 0,1,2,4,5 outstanding, commit_ready held low
    send_cmd(8'h44, 3'd2);
    cycles(2);
    check("bp_outstanding", outstanding, 4'd5);
    commit_ready = 1'b0;
    base = desc_cnt;
    send_resp(3'd0, 8'h40, 1'b0, 1'b0, 1'b1);
    send_resp(3'd1, 8'h41, 1'b0, 1'b0, 1'b1);
    send_resp(3'd2, 8'h42, 1'b0, 1'b0, 1'b1);
    send_resp(3'd4, 8'h43, 1'b0, 1'b0, 1'b1);
    fork
      send_resp(3'd5, 8'h44, 1'b0, 1'b0, 1'b1);
    join_none
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("bp_resp_ready_low", resp_ready, 1'b0);
    check("bp_four_descs", desc_cnt - base, 4);
    check("bp_commit_valid", commit_valid, 1'b1);
    check("bp_outstanding_held", outstanding, 4'd1);
    @(posedge clk);
    #1 commit_ready = 1'b1;
    wait fork;
    cycles(10);
    check("bp_drained_outstanding", outstanding, 4'd0);
    check("bp_drained_commit", commit_valid, 1'b0);

    // Mid-operation reset with 3 outstanding and 2 pending commits
    commit_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_cmd(8'h50 + 8'(i), 3'(i));
    send_resp(3'd3, 8'h53, 1'b0, 1'b0, 1'b1);
    send_resp(3'd4, 8'h54, 1'b0, 1'b0, 1'b1);
    cycles(3);
    @(negedge clk);
    check("pre_rst_outstanding", outstanding, 4'd3);
    check("pre_rst_commit_valid", commit_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outstanding", outstanding, 4'd0);
    check("mid_rst_commit_valid", commit_valid, 1'b0);
    check("mid_rst_desc_valid", desc_valid, 1'b0);
    check("mid_rst_req_valid", req_valid, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b0);
    exp_commit_q.delete();
    exp_desc_q.delete();
    exp_req_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    commit_ready = 1'b1;
    cycles(2);

    // Fresh start after reset: tag 0 must be free again
    send_cmd(8'd9, 3'd0);
    cycles(2);
    send_resp(3'd0, 8'h99, 1'b0, 1'b0, 1'b1);
    cycles(6);
    check("post_rst_outstanding", outstanding, 4'd0);

    check("tag_err_total", tag_err_pulses, 1);
    check("req_q_drained", exp_req_q.size(), 0);
    check("desc_q_drained", exp_desc_q.size(), 0);
    check("commit_q_drained", exp_commit_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
